// File: rtl/spin_sequencer_if.sv
// Player-facing bus of the slot-machine game controller: button/tick
// requests in, reel digits, credit state and win indication out.
interface spin_sequencer_if;
   logic       tick;
   logic       spin;
   logic       up;
   logic       down;
   logic [3:0] reel0;
   logic [3:0] reel1;
   logic [3:0] reel2;
   logic [6:0] credits;
   logic [1:0] bet;
   logic       busy;
   logic       win;
   logic [6:0] payout;
   logic       no_credit;

   modport master (
      output tick, spin, up, down,
      input  reel0, reel1, reel2, credits, bet, busy, win, payout, no_credit
   );

   modport slave (
      input  tick, spin, up, down,
      output reel0, reel1, reel2, credits, bet, busy, win, payout, no_credit
   );
endinterface

// File: rtl/spin_sequencer.sv
// Slot-machine play sequencer: takes a bet, rolls three reels on the divider
// tick, stops them one at a time, scores the result and keeps the balance.
module spin_sequencer #(
   parameter int REEL_TICKS    = 8,
   parameter int START_CREDITS = 20,
   parameter int MAX_CREDITS   = 99,
   parameter int MAX_BET       = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   spin_sequencer_if.slave  bus
);

   localparam int CNT_W = $clog2(REEL_TICKS + 1);

   typedef enum logic [2:0] {IDLE, SPIN0, SPIN1, SPIN2, SCORE} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [3:0]       entropy;
   logic [3:0]       reel0, reel1, reel2;
   logic [3:0]       reel0_nxt, reel1_nxt, reel2_nxt;
   logic [6:0]       credits, credits_nxt;
   logic [6:0]       payout, payout_nxt;
   logic [1:0]       bet, bet_nxt;
   logic             busy, win, win_nxt;
   logic             no_credit;
   logic             accept;
   logic [6:0]       pay;

   // Operands are always 0..9, so one conditional subtract is a full mod 10.
   function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
      logic [4:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 5'd10) ? 4'(s - 5'd10) : s[3:0];
   endfunction

   function automatic logic [6:0] sat_credits(input logic [6:0] c, input logic [6:0] p);
      logic [7:0] s;
      s = {1'b0, c} + {1'b0, p};
      return (s > 8'(MAX_CREDITS)) ? 7'(MAX_CREDITS) : s[6:0];
   endfunction

   assign no_credit = (credits < {5'd0, bet});
   assign accept    = (state == IDLE) && bus.spin && !no_credit;

   always_comb begin
      pay = 7'd0;
      if (reel0 == reel1 && reel1 == reel2)
         pay = 7'({5'd0, bet} * 7'd10);
      else if (reel0 == reel1 || reel1 == reel2 || reel0 == reel2)
         pay = {4'd0, bet, 1'b0};
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      reel0_nxt   = reel0;
      reel1_nxt   = reel1;
      reel2_nxt   = reel2;
      credits_nxt = credits;
      payout_nxt  = payout;
      bet_nxt     = bet;
      win_nxt     = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               credits_nxt = credits - {5'd0, bet};
               reel2_nxt   = add_mod10(reel2, entropy);
               cnt_nxt     = '0;
               state_nxt   = SPIN0;
            end else if (bus.up && !bus.down && bet != 2'(MAX_BET)) begin
               bet_nxt = bet + 2'd1;
            end else if (bus.down && !bus.up && bet != 2'd1) begin
               bet_nxt = bet - 2'd1;
            end
         end
         SPIN0, SPIN1, SPIN2: begin
            if (bus.tick) begin
               if (state == SPIN0) reel0_nxt = add_mod10(reel0, 4'd1);
               if (state != SPIN2) reel1_nxt = add_mod10(reel1, 4'd3);
               reel2_nxt = add_mod10(reel2, 4'd7);
               if (cnt == CNT_W'(REEL_TICKS - 1)) begin
                  cnt_nxt = '0;
                  case (state)
                     SPIN0:   state_nxt = SPIN1;
                     SPIN1:   state_nxt = SPIN2;
                     default: state_nxt = SCORE;
                  endcase
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end
         end
         SCORE: begin
            payout_nxt  = pay;
            credits_nxt = sat_credits(credits, pay);
            win_nxt     = (pay != 7'd0);
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         entropy <= 4'd0;
         reel0   <= 4'd0;
         reel1   <= 4'd0;
         reel2   <= 4'd0;
         credits <= 7'(START_CREDITS);
         payout  <= 7'd0;
         bet     <= 2'd1;
         busy    <= 1'b0;
         win     <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         entropy <= (entropy == 4'd9) ? 4'd0 : entropy + 4'd1;
         reel0   <= reel0_nxt;
         reel1   <= reel1_nxt;
         reel2   <= reel2_nxt;
         credits <= credits_nxt;
         payout  <= payout_nxt;
         bet     <= bet_nxt;
         busy    <= (state_nxt != IDLE);
         win     <= win_nxt;
      end
   end

   assign bus.reel0     = reel0;
   assign bus.reel1     = reel1;
   assign bus.reel2     = reel2;
   assign bus.credits   = credits;
   assign bus.bet       = bet;
   assign bus.busy      = busy;
   assign bus.win       = win;
   assign bus.payout    = payout;
   assign bus.no_credit = no_credit;

endmodule

// File: tb/tb_spin_sequencer.sv
// Bench for spin_sequencer: directed plays with hand-computed reel, payout and
// credit results queued at issue time and checked when each play ends.
module tb_spin_sequencer;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   spin_sequencer_if bus ();
   spin_sequencer_if low ();

   spin_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   spin_sequencer #(.START_CREDITS(2)) dut_low (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (low)
   );

   typedef struct {
      int r0;
      int r1;
      int r2;
      int pay;
      int cred;
   } exp_t;

   exp_t q[$];
   int   nvec = 0;
   int   nerr = 0;
   int   ent;

   always #5 clk = ~clk;

   // Reference entropy: value present in the current cycle, counted from reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ent <= 0;
      else        ent <= (ent + 1) % 10;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Divider tick: one cycle in every four.
   initial begin
      int c;
      c = 0;
      bus.tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         c++;
         bus.tick = (c % 4 == 0);
      end
   end

   // Monitor: a busy->idle transition marks the end of a play.
   initial begin
      bit   pb, pend, chk_win;
      int   nt;
      exp_t x;
      pb = 0; pend = 0; chk_win = 0; nt = 0;
      forever begin
         @(negedge clk or negedge rst_n);
         if (!rst_n) begin
            pb = 0; pend = 0; chk_win = 0; nt = 0;
         end else begin
            if (chk_win) begin
               check("win_one_cycle", bus.win, 0);
               chk_win = 0;
            end
            if (bus.busy === 1'b1) begin
               nt   = nt + int'(pend);
               pend = bus.tick;
            end else if (pb) begin
               if (q.size() == 0) begin
                  nvec++; nerr++;
                  $display("FAIL unexpected_play_end: got end of play, expected none");
               end else begin
                  x = q.pop_front();
                  check("spin_ticks", nt, 24);
                  check("reel0", bus.reel0, x.r0);
                  check("reel1", bus.reel1, x.r1);
                  check("reel2", bus.reel2, x.r2);
                  check("payout", bus.payout, x.pay);
                  check("credits", bus.credits, x.cred);
                  check("win", bus.win, (x.pay > 0) ? 1 : 0);
                  chk_win = 1;
               end
               nt = 0; pend = 0;
            end
            pb = (bus.busy === 1'b1);
         end
      end
   end

   task automatic do_reset(input string tag);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      check({tag, "_reel0"}, bus.reel0, 0);
      check({tag, "_reel1"}, bus.reel1, 0);
      check({tag, "_reel2"}, bus.reel2, 0);
      check({tag, "_credits"}, bus.credits, 20);
      check({tag, "_bet"}, bus.bet, 1);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_win"}, bus.win, 0);
      check({tag, "_payout"}, bus.payout, 0);
      check({tag, "_no_credit"}, bus.no_credit, 0);
      check({tag, "_low_credits"}, low.credits, 2);
      rst_n = 1'b1;
   endtask

   task automatic pulse(input logic u, input logic d, input int exp_bet, input string name);
      bus.up = u; bus.down = d;
      @(posedge clk); #1;
      bus.up = 1'b0; bus.down = 1'b0;
      check(name, bus.bet, exp_bet);
   endtask

   task automatic spin_at(input int e);
      while (ent != e) begin
         @(posedge clk); #1;
      end
      bus.spin = 1'b1;
      @(posedge clk); #1;
      bus.spin = 1'b0;
      check("busy_rise", bus.busy, 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (bus.busy === 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy === 1'b1) begin
         nvec++; nerr++;
         $display("FAIL idle_timeout: busy still %0d after %0d cycles, expected 0", bus.busy, n);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic play(input int e, input int r0, input int r1, input int r2,
                       input int pay, input int cred);
      exp_t x;
      x = '{r0, r1, r2, pay, cred};
      q.push_back(x);
      spin_at(e);
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.spin = 1'b0; bus.up = 1'b0; bus.down = 1'b0;
      low.tick = 1'b0; low.spin = 1'b0; low.up = 1'b0; low.down = 1'b0;

      do_reset("reset");
      repeat (12) @(posedge clk);
      #1;
      check("idle_busy", bus.busy, 0);

      // Bet adjust with saturation at both ends.
      pulse(1, 0, 2, "bet_up1");
      pulse(1, 0, 3, "bet_up2");
      pulse(1, 0, 3, "bet_up_sat");
      pulse(0, 1, 2, "bet_dn1");
      pulse(0, 1, 1, "bet_dn2");
      pulse(0, 1, 1, "bet_dn_sat");
      pulse(1, 1, 1, "bet_up_down");

      // Entropy 0 from reset: triple eights; up while busy is ignored.
      do_reset("rst_play1");
      q.push_back('{8, 8, 8, 10, 29});
      spin_at(0);
      repeat (5) @(posedge clk);
      #1 bus.up = 1'b1;
      @(posedge clk); #1 bus.up = 1'b0;
      check("bet_busy_up", bus.bet, 1);
      wait_idle();

      // Entropy 3 from reset: pair only.
      do_reset("rst_play2");
      play(3, 8, 8, 1, 2, 21);

      // Build credits up to 95, then saturate on a bet-3 triple.
      do_reset("rst_sat");
      pulse(1, 0, 2, "sat_bet_up1");
      pulse(1, 0, 3, "sat_bet_up2");
      play(0, 8, 8, 8, 30, 47);
      play(0, 6, 6, 6, 30, 74);
      pulse(0, 1, 2, "sat_bet_dn");
      play(0, 4, 4, 4, 20, 92);
      pulse(1, 0, 3, "sat_bet_up3");
      play(5, 2, 2, 7, 6, 95);
      play(5, 0, 0, 0, 30, 99);

      // Insufficient credits on the low-balance instance.
      low.up = 1'b1;
      repeat (2) @(posedge clk);
      #1 low.up = 1'b0;
      check("low_bet", low.bet, 3);
      check("low_no_credit", low.no_credit, 1);
      low.spin = 1'b1;
      @(posedge clk); #1 low.spin = 1'b0;
      check("low_spin_busy", low.busy, 0);
      check("low_spin_credits", low.credits, 2);
      repeat (3) @(posedge clk);
      #1;
      check("low_busy_hold", low.busy, 0);
      low.down = 1'b1;
      @(posedge clk); #1 low.down = 1'b0;
      check("low_bet_dn", low.bet, 2);
      check("low_no_credit_clear", low.no_credit, 0);

      // Abort during SPIN1, then a fresh play after release.
      spin_at(0);
      repeat (48) @(posedge clk);
      #1;
      check("mid_busy", bus.busy, 1);
      check("mid_reel0_frozen", bus.reel0, 8);
      do_reset("midrst");
      play(0, 8, 8, 8, 10, 29);

      check("queue_empty", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/spin_sequencer.md
Name: spin_sequencer

Overview:
- Game controller for the slot machine; sequences one play of three reels.
- Accepts bet adjust and spin requests and rolls the reels on a divided tick, stopping them one at a time.
- Scores the result and keeps the credit balance.
- Its reel digits, credits and win pulse feed the display/LED/sound logic. It runs on the single system clock and uses the clock-divider tick as an enable, never as a clock.

Parameters:
- REEL_TICKS, 8, ticks spent in each SPINk state before reel k stops (>=1)
- START_CREDITS, 20, credit balance after reset (<= MAX_CREDITS)
- MAX_CREDITS, 99, credit saturation ceiling (<=127)
- MAX_BET, 3, largest bet (1..3)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- tick  input  1  one-cycle reel step enable from the clock divider
- spin  input  1  one-cycle debounced spin request
- up  input  1  one-cycle debounced bet increment
- down  input  1  one-cycle debounced bet decrement
- reel0, reel1, reel2  output  4 each  reel digits, always 0..9
- credits  output  7  credit balance
- bet  output  2  current bet, 1..MAX_BET
- busy  output  1  high in every state except IDLE
- win  output  1  one-cycle pulse on a nonzero payout
- payout  output  7  last payout amount; held until the next SCORE
- no_credit  output  1  combinational; high when credits < bet

Behaviour:
- Reset (async, rst_n=0):
  - reels 0,0,0; credits=START_CREDITS; bet=1; busy=0; win=0; payout=0
  - state IDLE; tick counter 0; entropy 0
- Reset mid-spin aborts immediately; the deducted bet is not refunded separately, because credits reload to START_CREDITS.
- entropy: free-running mod-10 counter, +1 every clk (0→1→…→9→0), in all states.
- State machine: IDLE → SPIN0 → SPIN1 → SPIN2 → SCORE → IDLE.
- IDLE:
  - spin=1 and credits>=bet: accept the spin.
    - Next edge: credits -= bet; reel2 <= (reel2+entropy) mod 10, using the entropy value sampled in the accept cycle.
    - Tick counter cleared; state SPIN0; busy=1 from the next cycle.
  - spin=1 and credits<bet: ignored; stay in IDLE.
  - Bet adjust, only when spin is not accepted that cycle:
    - up alone: bet+1, saturating at MAX_BET
    - down alone: bet-1, saturating at 1
    - up and down together: no change
  - spin has priority over up/down in the same cycle; the bet used is the pre-edge value.
  - A tick in the accept cycle is not counted.
- SPINk (k=0,1,2):
  - On each tick, every rolling reel steps mod 10: reel0 +1, reel1 +3, reel2 +7. Reel j rolls while j>=k.
  - Counter increments per tick. On the REEL_TICKS-th tick, the stepped value of reel k is final and reel k freezes.
  - Counter clears and the state advances (SPIN2 advances to SCORE).
  - spin, up and down are ignored in every busy state.
- SCORE (exactly one cycle, no tick dependence):
  - All three reels equal: pay = bet*10.
  - Else any two equal: pay = bet*2.
  - Else pay = 0.
  - At the exit edge: payout <= pay; credits <= min(credits+pay, MAX_CREDITS). Compute in 8 bits before saturating.
  - win=1 in the cycle after SCORE (registered) iff pay>0.
  - Next state IDLE.
- Latency: spin accept → final SCORE edge = 3*REEL_TICKS ticks + 2 clk.
- Outputs are registered except no_credit. Reels never leave 0..9 (all arithmetic mod 10 in 5 bits).

Test Plan:
- Reset then idle, no inputs → reels 0/0/0, credits=20, bet=1, busy=0, no_credit=0, entropy cycling 0..9.
- Bet adjust: up x3 → bet=2,3,3; down x3 → 2,1,1; up+down together → unchanged; up during busy → ignored.
- Spin from reset, accepted when entropy=0, bet=1:
  - busy for 24 ticks + 2 clk
  - reels stop 8,8,8 (reel0 after tick 8, reel1 after tick 16, reel2 after tick 24)
  - payout=10, win pulse, credits=20-1+10=29
- Spin from reset, accepted when entropy=3, bet=1 → reels 8/8/1, payout=2, credits=21, win pulses.
- Saturation and insufficient credits:
  - Force credits=95 via a play sequence, bet=3, triple → credits=99.
  - With credits=2 and bet=3: spin ignored, no_credit=1, busy stays 0.
- Reset mid-SPIN1 (rst_n low for 1 ns between edges) → immediate reels 0/0/0, credits=20, busy=0; a new spin is accepted normally after release.
